// File: rtl/croma_menu_ctrl.sv
// croma_menu_ctrl: three-button menu controller for the chroma-key tone and
// letter/background colour settings. Raw buttons are synchronized and
// debounced; up/down step the field selected by the menu mode, sel cycles
// the mode. Optional auto-repeat on held up/down is enabled by defining
// CROMA_AUTOREPEAT_EN (disabled by default, single step per press).
module croma_menu_ctrl #(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned HOLD_CYCLES = 400,
  parameter int unsigned REP_CYCLES  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [7:0] ton,
  output logic [2:0] color_l,
  output logic [2:0] color_p,
  output logic [1:0] mode,
  output logic       upd
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {
    TONE    = 2'b00,
    COLOR_L = 2'b01,
    COLOR_P = 2'b10
  } mode_t;

  // Button index: 0 = up, 1 = down, 2 = sel
  logic [2:0]    raw_c;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [2:0]    deb_q;
  logic [DW-1:0] dcnt [3];
  logic [2:0]    press_c;
  logic          both_c;
  logic          inc_c;
  logic          dec_c;
  mode_t         state;

  assign raw_c   = {btn_sel, btn_down, btn_up};
  assign press_c = deb & ~deb_q;
  assign both_c  = deb[0] & deb[1];
  assign mode    = state;

  // Synchronize and debounce each button; one stable-run counter per button
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef CROMA_AUTOREPEAT_EN
  localparam int unsigned RMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rcnt [2];
  logic [1:0]    rphase;
  logic [1:0]    fire_c;

  // A repeat fires HOLD_CYCLES after the press step, then every REP_CYCLES
  always_comb begin
    fire_c = '0;
    for (int i = 0; i < 2; i++) begin
      fire_c[i] = deb[i] & ~both_c & ~press_c[i] &
                  (rphase[i] ? (rcnt[i] == RW'(REP_CYCLES - 1))
                             : (rcnt[i] == RW'(HOLD_CYCLES - 1)));
    end
  end

  // Repeat timers run only while a single direction is held
  always_ff @(posedge clk) begin
    if (reset) begin
      rphase <= '0;
      for (int i = 0; i < 2; i++) rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!deb[i] || both_c || press_c[i]) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b0;
        end else if (fire_c[i]) begin
          rcnt[i]   <= '0;
          rphase[i] <= 1'b1;
        end else begin
          rcnt[i] <= rcnt[i] + RW'(1);
        end
      end
    end
  end

  assign inc_c = (press_c[0] | fire_c[0]) & ~both_c;
  assign dec_c = (press_c[1] | fire_c[1]) & ~both_c;
`else
  assign inc_c = press_c[0] & ~both_c;
  assign dec_c = press_c[1] & ~both_c;
`endif

  // Menu FSM and saturating field update; sel wins over a same-cycle step
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TONE;
      ton     <= 8'hA4;
      color_l <= 3'b000;
      color_p <= 3'b111;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (press_c[2]) begin
        case (state)
          TONE:    state <= COLOR_L;
          COLOR_L: state <= COLOR_P;
          default: state <= TONE;
        endcase
      end else if (inc_c || dec_c) begin
        case (state)
          TONE: begin
            if (inc_c && ton != 8'hFF) begin
              ton <= ton + 8'd1;
              upd <= 1'b1;
            end else if (dec_c && ton != 8'h00) begin
              ton <= ton - 8'd1;
              upd <= 1'b1;
            end
          end
          COLOR_L: begin
            if (inc_c && color_l != 3'd7) begin
              color_l <= color_l + 3'd1;
              upd     <= 1'b1;
            end else if (dec_c && color_l != 3'd0) begin
              color_l <= color_l - 3'd1;
              upd     <= 1'b1;
            end
          end
          default: begin
            if (inc_c && color_p != 3'd7) begin
              color_p <= color_p + 3'd1;
              upd     <= 1'b1;
            end else if (dec_c && color_p != 3'd0) begin
              color_p <= color_p - 3'd1;
              upd     <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_croma_menu_ctrl.sv
// Directed self-checking bench for croma_menu_ctrl (DEB=4, HOLD=20, REP=5).
module tb_croma_menu_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 20;
  localparam int unsigned REP  = 5;

  localparam int B_UP  = 0;
  localparam int B_DN  = 1;
  localparam int B_SEL = 2;

  logic       clk;
  logic       reset;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic [7:0] ton;
  logic [2:0] color_l;
  logic [2:0] color_p;
  logic [1:0] mode;
  logic       upd;

  int n_checks;
  int n_errors;
  int upd_total;
  int u0;

  croma_menu_ctrl #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD),
    .REP_CYCLES (REP)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .btn_sel (btn_sel),
    .ton     (ton),
    .color_l (color_l),
    .color_p (color_p),
    .mode    (mode),
    .upd     (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // upd pulse counter sampled mid-cycle
  always @(negedge clk) if (upd === 1'b1) upd_total++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      B_UP:    btn_up   = v;
      B_DN:    btn_down = v;
      default: btn_sel  = v;
    endcase
  endtask

  task automatic press(input int which, input int hold);
    set_btn(which, 1'b1);
    tick(hold);
    set_btn(which, 1'b0);
    tick(12);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    upd_total = 0;
    reset     = 1'b1;
    btn_up    = 1'b0;
    btn_down  = 1'b0;
    btn_sel   = 1'b0;

    // Reset values and idle
    tick(2);
    reset = 1'b0;
    check("rst_ton", 32'(ton), 32'hA4);
    check("rst_color_l", 32'(color_l), 32'd0);
    check("rst_color_p", 32'(color_p), 32'd7);
    check("rst_mode", 32'(mode), 32'd0);
    check("rst_upd", 32'(upd), 32'd0);
    tick(10);
    check("idle_ton", 32'(ton), 32'hA4);
    check("idle_color_p", 32'(color_p), 32'd7);
    check("idle_upd", 32'(upd_total), 32'd0);

    // Glitch rejected, then one clean press with exact latency
    u0 = upd_total;
    btn_up = 1'b1;
    tick(3);
    btn_up = 1'b0;
    tick(12);
    check("glitch_ton", 32'(ton), 32'hA4);
    btn_up = 1'b1;
    tick(DEB + 2);
    check("lat_before", 32'(ton), 32'hA4);
    tick(1);
    check("lat_at", 32'(ton), 32'hA5);
    check("lat_upd", 32'(upd), 32'd1);
    tick(3);
    btn_up = 1'b0;
    tick(12);
    check("press_upd_cnt", 32'(upd_total - u0), 32'd1);

    // Two sel presses, then down saturation on color_p
    press(B_SEL, 10);
    press(B_SEL, 10);
    check("sel_mode", 32'(mode), 32'd2);
    for (int i = 0; i < 3; i++) press(B_DN, 10);
    check("dn3_color_p", 32'(color_p), 32'd4);
    for (int i = 0; i < 4; i++) press(B_DN, 10);
    check("dn7_color_p", 32'(color_p), 32'd0);
    u0 = upd_total;
    for (int i = 0; i < 3; i++) press(B_DN, 10);
    check("dn10_color_p", 32'(color_p), 32'd0);
    check("dn_sat_upd", 32'(upd_total - u0), 32'd0);
    check("dn_ton_kept", 32'(ton), 32'hA5);
    check("dn_color_l_kept", 32'(color_l), 32'd0);
    check("dn_mode_kept", 32'(mode), 32'd2);

    // Held up in TONE: auto-repeat when enabled, single step otherwise
    do_reset();
    btn_up = 1'b1;
    tick(DEB + 3);
    check("hold_first", 32'(ton), 32'hA5);
    tick(HOLD - 1);
    check("hold_pre_rep", 32'(ton), 32'hA5);
    tick(1);
`ifdef CROMA_AUTOREPEAT_EN
    check("hold_rep1", 32'(ton), 32'hA6);
`else
    check("hold_rep1", 32'(ton), 32'hA5);
`endif
    tick(12);
    btn_up = 1'b0;
    tick(20);
`ifdef CROMA_AUTOREPEAT_EN
    check("hold_final", 32'(ton), 32'hA9);
`else
    check("hold_final", 32'(ton), 32'hA5);
`endif

    // Up and down together: no step
    do_reset();
    u0 = upd_total;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    tick(30);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    tick(12);
    check("both_ton", 32'(ton), 32'hA4);
    check("both_upd", 32'(upd_total - u0), 32'd0);

    // sel and up aligned: mode advances, step dropped
    btn_sel = 1'b1;
    btn_up  = 1'b1;
    tick(10);
    btn_sel = 1'b0;
    btn_up  = 1'b0;
    tick(12);
    check("align_mode", 32'(mode), 32'd1);
    check("align_ton", 32'(ton), 32'hA4);
    check("align_color_l", 32'(color_l), 32'd0);
    check("align_upd", 32'(upd_total - u0), 32'd0);

    // Reset during held press at FE
    do_reset();
    for (int i = 0; i < 90; i++) press(B_UP, 8);
    check("climb_fe", 32'(ton), 32'hFE);
    btn_up = 1'b1;
    tick(3);
    do_reset();
    check("midrst_ton", 32'(ton), 32'hA4);
    check("midrst_mode", 32'(mode), 32'd0);
    tick(DEB + 2);
    check("midrst_before", 32'(ton), 32'hA4);
    tick(1);
    check("midrst_step", 32'(ton), 32'hA5);
    btn_up = 1'b0;
    tick(12);

    // Upper saturation of ton
    do_reset();
    for (int i = 0; i < 90; i++) press(B_UP, 8);
    check("climb2_fe", 32'(ton), 32'hFE);
    u0 = upd_total;
    press(B_UP, 8);
    check("sat_ff", 32'(ton), 32'hFF);
    check("sat_ff_upd", 32'(upd_total - u0), 32'd1);
    u0 = upd_total;
    press(B_UP, 8);
    check("sat_ff_hold", 32'(ton), 32'hFF);
    check("sat_ff_no_upd", 32'(upd_total - u0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
